// File: rtl/derandomizer_if.sv
// Symbol-stream bundle between the demapper, the derandomizer and the frame buffer.
// The master drives received symbols; the slave returns derandomized payload and lock status.
interface derandomizer_if;
    logic [1:0] i_sym;
    logic       i_valid;
    logic [1:0] o_data;
    logic       o_valid;
    logic       o_sof;
    logic       o_lock;
    logic       o_asm_miss;

    modport master (
        output i_sym, i_valid,
        input  o_data, o_valid, o_sof, o_lock, o_asm_miss
    );

    modport slave (
        input  i_sym, i_valid,
        output o_data, o_valid, o_sof, o_lock, o_asm_miss
    );
endinterface

// File: rtl/derandomizer.sv
// CCSDS Gold-sequence derandomizer: finds the ASM, restarts the x/y PRN at every frame
// and XORs it onto the 2-bit payload symbols, keeping lock through a miss flywheel.
module derandomizer #(
    parameter int                   ASM_LEN    = 16,
    parameter logic [2*ASM_LEN-1:0] ASM        = 32'h1ACFFC1D,
    parameter int                   FRAME_SYMS = 64,
    parameter int                   MISS_MAX   = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    derandomizer_if.slave bus
);
    localparam int CNT_MAX = (FRAME_SYMS > ASM_LEN) ? FRAME_SYMS : ASM_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int MISS_W  = (MISS_MAX > 0) ? $clog2(MISS_MAX + 1) : 1;
    localparam int HIST_W  = 2 * ASM_LEN - 2;

    localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(FRAME_SYMS - 1);
    localparam logic [CNT_W-1:0]  LAST_ASM  = CNT_W'(ASM_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(MISS_MAX);
    localparam logic [17:0]       X_SEED    = 18'h00001;
    localparam logic [17:0]       Y_SEED    = 18'h3FFFF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        DATA   = 2'd1,
        CHECK  = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [HIST_W-1:0]    hist, hist_nx;
    logic [2*ASM_LEN-1:0] win_nx;
    logic                 match;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [MISS_W-1:0]    miss, miss_nx;
    logic [17:0]          x, x_nx, y, y_nx;
    logic [1:0]           prn;

    logic [1:0] data_q, data_nx;
    logic       valid_q, valid_nx;
    logic       sof_q, sof_nx;
    logic       lock_q;
    logic       amiss_q, amiss_nx;

    function automatic logic [17:0] x_step(input logic [17:0] v);
        return {v[7] ^ v[0], v[17:1]};
    endfunction

    function automatic logic [17:0] y_step(input logic [17:0] v);
        return {v[10] ^ v[7] ^ v[5] ^ v[0], v[17:1]};
    endfunction

    // The window holds the previous ASM_LEN-1 symbols; the match includes the symbol arriving now.
    assign win_nx = {hist, bus.i_sym};
    assign match  = (win_nx == ASM);
    assign prn    = {x[4] ^ x[6] ^ x[15] ^ (^{y[15:8], y[6:5]}), x[0] ^ y[0]};

    always_comb begin
        state_nx = state;
        hist_nx  = hist;
        cnt_nx   = cnt;
        miss_nx  = miss;
        x_nx     = x;
        y_nx     = y;
        data_nx  = '0;
        valid_nx = 1'b0;
        sof_nx   = 1'b0;
        amiss_nx = 1'b0;
        if (bus.i_valid) begin
            hist_nx = win_nx[HIST_W-1:0];
            case (state)
                SEARCH: begin
                    if (match) begin
                        x_nx     = X_SEED;
                        y_nx     = Y_SEED;
                        cnt_nx   = '0;
                        state_nx = DATA;
                    end
                end
                DATA: begin
                    data_nx  = bus.i_sym ^ prn;
                    valid_nx = 1'b1;
                    sof_nx   = (cnt == '0);
                    x_nx     = x_step(x);
                    y_nx     = y_step(y);
                    if (cnt == LAST_DATA) begin
                        cnt_nx   = '0;
                        state_nx = CHECK;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (cnt == LAST_ASM) begin
                        cnt_nx   = '0;
                        x_nx     = X_SEED;
                        y_nx     = Y_SEED;
                        state_nx = DATA;
                        if (match) begin
                            miss_nx = '0;
                        end else begin
                            amiss_nx = 1'b1;
                            // Flywheel: keep framing blind until too many consecutive misses.
                            if (miss >= MISS_LIM) begin
                                miss_nx  = '0;
                                state_nx = SEARCH;
                            end else begin
                                miss_nx = miss + 1'b1;
                            end
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= SEARCH;
        end else begin
            state <= state_nx;
        end
    end

    // Output stage: everything the frame buffer sees is registered one cycle after acceptance.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hist    <= '0;
            cnt     <= '0;
            miss    <= '0;
            x       <= X_SEED;
            y       <= Y_SEED;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            lock_q  <= 1'b0;
            amiss_q <= 1'b0;
        end else begin
            hist    <= hist_nx;
            cnt     <= cnt_nx;
            miss    <= miss_nx;
            x       <= x_nx;
            y       <= y_nx;
            data_q  <= data_nx;
            valid_q <= valid_nx;
            sof_q   <= sof_nx;
            lock_q  <= (state_nx != SEARCH);
            amiss_q <= amiss_nx;
        end
    end

    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_sof      = sof_q;
    assign bus.o_lock     = lock_q;
    assign bus.o_asm_miss = amiss_q;
endmodule

// File: tb/tb_derandomizer.sv
// Bench for the derandomizer: frame-level model of lock/miss behaviour plus a PRN table
// built from the Gold-sequence recurrences; a compare process checks every output symbol.
module tb_derandomizer;
    localparam int          ASM_LEN    = 16;
    localparam int          FRAME_SYMS = 64;
    localparam int          MISS_MAX   = 2;
    localparam logic [31:0] ASM        = 32'h1ACFFC1D;
    localparam logic [31:0] BAD_ASM    = ASM ^ 32'h0000_0100;

    logic i_clk;
    logic i_reset;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    derandomizer_if bus();

    derandomizer #(
        .ASM_LEN(ASM_LEN), .ASM(ASM), .FRAME_SYMS(FRAME_SYMS), .MISS_MAX(MISS_MAX)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [1:0] data;
        logic       sof;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [1:0] prn_tab [FRAME_SYMS];
    int         n_checks  = 0;
    int         n_pass    = 0;
    int         seen_miss = 0;
    int         exp_miss  = 0;
    int         mmiss     = 0;
    bit         mlock     = 1'b0;
    bit         gap_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // PRN as bit sequences: register bit i at step k equals s[k+i].
    initial begin : build_prn
        logic sx [FRAME_SYMS+18];
        logic sy [FRAME_SYMS+18];
        logic z;
        for (int n = 0; n < 18; n++) begin
            sx[n] = (n == 0);
            sy[n] = 1'b1;
        end
        for (int n = 18; n < FRAME_SYMS + 18; n++) begin
            sx[n] = sx[n-11] ^ sx[n-18];
            sy[n] = sy[n-8] ^ sy[n-11] ^ sy[n-13] ^ sy[n-18];
        end
        for (int k = 0; k < FRAME_SYMS; k++) begin
            z = sx[k+4] ^ sx[k+6] ^ sx[k+15] ^ sy[k+5] ^ sy[k+6];
            for (int j = 8; j <= 15; j++) z = z ^ sy[k+j];
            prn_tab[k] = {z, sx[k] ^ sy[k]};
        end
    end

    always @(negedge i_clk) begin
        if (i_reset === 1'b0) begin
            if (bus.o_asm_miss === 1'b1) seen_miss++;
            if (bus.o_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("no_unexpected_valid", 32'(bus.o_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("o_data", 32'(bus.o_data), 32'(e.data));
                    check("o_sof", 32'(bus.o_sof), 32'(e.sof));
                    check("o_lock_in_data", 32'(bus.o_lock), 32'd1);
                end
            end else if (bus.o_sof !== 1'b0) begin
                check("sof_needs_valid", 32'(bus.o_sof), 32'd0);
            end
        end
    end

    task automatic drive(input logic [1:0] s);
        if (gap_en) begin
            while ($urandom_range(1, 0) == 1) begin
                @(negedge i_clk);
                bus.i_valid = 1'b0;
                bus.i_sym   = 2'($urandom);
            end
        end
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_sym   = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            bus.i_valid = 1'b0;
        end
    endtask

    task automatic send_asm(input bit good);
        logic [31:0] p;
        p = good ? ASM : BAD_ASM;
        for (int i = 0; i < ASM_LEN; i++) drive(p[31-2*i -: 2]);
        if (!mlock) begin
            if (good) mlock = 1'b1;
        end else if (good) begin
            mmiss = 0;
        end else begin
            exp_miss++;
            mmiss++;
            if (mmiss > MISS_MAX) begin
                mlock = 1'b0;
                mmiss = 0;
            end
        end
    endtask

    // Transmitter view: original symbol XOR PRN goes on the line; a locked receiver returns the original.
    task automatic send_payload(input int n, input int mode);
        logic [1:0] orig;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       orig = 2'b00;
                1:       orig = 2'(i);
                default: orig = 2'($urandom);
            endcase
            if (mlock) exp_q.push_back({orig, i == 0});
            drive(orig ^ prn_tab[i]);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_o_valid"}, 32'(bus.o_valid), 32'd0);
        check({tag, "_o_data"}, 32'(bus.o_data), 32'd0);
        check({tag, "_o_sof"}, 32'(bus.o_sof), 32'd0);
        check({tag, "_o_lock"}, 32'(bus.o_lock), 32'd0);
        check({tag, "_o_asm_miss"}, 32'(bus.o_asm_miss), 32'd0);
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        bus.i_valid = 1'b0;
        exp_q.delete();
        mlock = 1'b0;
        mmiss = 0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_sym   = 2'b00;
        i_reset     = 1'b1;
        repeat (2) @(negedge i_clk);
        check_outputs_zero("reset");
        i_reset = 1'b0;

        // First two PRN symbols: received 00,00 must come out as 00 then 01.
        send_asm(1'b1);
        exp_q.push_back({prn_tab[0], 1'b1});
        drive(2'b00);
        exp_q.push_back({prn_tab[1], 1'b0});
        drive(2'b00);
        check("first_out_data", 32'(bus.o_data), 32'd0);
        check("first_out_sof", 32'(bus.o_sof), 32'd1);
        idle(1);
        check("second_out_data", 32'(bus.o_data), 32'd1);
        check("second_out_sof", 32'(bus.o_sof), 32'd0);
        do_reset();

        // One clean frame of randomized zeros.
        send_asm(1'b1);
        send_payload(FRAME_SYMS, 0);
        idle(2);
        check("frame1_lock", 32'(bus.o_lock), 32'd1);
        check("frame1_all_out", 32'(exp_q.size()), 32'd0);

        // Two corrupted ASMs: flywheel keeps lock.
        send_asm(1'b0);
        send_payload(FRAME_SYMS, 1);
        send_asm(1'b0);
        send_payload(FRAME_SYMS, 2);
        idle(2);
        check("flywheel_lock", 32'(bus.o_lock), 32'd1);
        check("flywheel_miss_count", 32'(seen_miss), 32'd2);
        check("flywheel_all_out", 32'(exp_q.size()), 32'd0);

        // Three consecutive misses drop lock; a fresh ASM relocks.
        send_asm(1'b1);
        send_payload(FRAME_SYMS, 1);
        send_asm(1'b0);
        send_payload(FRAME_SYMS, 0);
        send_asm(1'b0);
        send_payload(FRAME_SYMS, 2);
        send_asm(1'b0);
        idle(1);
        check("third_miss_pulse", 32'(bus.o_asm_miss), 32'd1);
        check("third_miss_unlock", 32'(bus.o_lock), 32'd0);
        repeat (8) drive(2'b00);
        idle(2);
        check("search_no_lock", 32'(bus.o_lock), 32'd0);
        send_asm(1'b1);
        send_payload(FRAME_SYMS, 1);
        idle(2);
        check("relock", 32'(bus.o_lock), 32'd1);
        check("total_misses", 32'(seen_miss), 32'd5);
        check("relock_all_out", 32'(exp_q.size()), 32'd0);

        // Random input gaps must not disturb framing or PRN.
        gap_en = 1'b1;
        send_asm(1'b1);
        send_payload(FRAME_SYMS, 2);
        send_asm(1'b1);
        send_payload(FRAME_SYMS, 1);
        gap_en = 1'b0;
        idle(2);
        check("gaps_lock", 32'(bus.o_lock), 32'd1);
        check("gaps_all_out", 32'(exp_q.size()), 32'd0);

        // Mid-payload reset clears outputs at once and forgets the frame.
        send_asm(1'b1);
        send_payload(20, 1);
        @(posedge i_clk);
        #1;
        check("pre_reset_valid", 32'(bus.o_valid), 32'd1);
        check("pre_reset_data", 32'(bus.o_data), 32'd3);
        i_reset     = 1'b1;
        bus.i_valid = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        mlock = 1'b0;
        mmiss = 0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (16) drive(2'b00);
        idle(2);
        check("post_reset_unlocked", 32'(bus.o_lock), 32'd0);
        send_asm(1'b1);
        send_payload(FRAME_SYMS, 0);
        idle(2);
        check("post_reset_relock", 32'(bus.o_lock), 32'd1);
        check("post_reset_all_out", 32'(exp_q.size()), 32'd0);
        check("miss_count_model", 32'(seen_miss), 32'(exp_miss));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
